clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Measuring end of the clock-divider path: takes a slow divided clock (or any slow square wave) and measures its period and high time in `clock_in` cycles.
- Used on-board to self-check divider outputs and to read back an unknown divisor.
- Single clock domain; `sig_in` is treated as asynchronous and synchronised internally.

Parameters:
- CNT_WIDTH, 28, width of the period/high-time counters and result outputs.
- TIMEOUT, 28'd100_000_000, max `clock_in` cycles from start to result before aborting.
- SYNC_STAGES, 2, flop stages in the `sig_in` synchroniser (minimum 2).

Ports:
- clock_in  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  slow signal to measure (async to `clock_in`).
- start  input  1  one-cycle request to begin one measurement.
- busy  output  1  high while a measurement is in progress.
- valid  output  1  one-cycle pulse; results updated this cycle.
- period  output  CNT_WIDTH  rising-to-rising interval, in `clock_in` cycles.
- high_time  output  CNT_WIDTH  rising-to-falling interval, in `clock_in` cycles.
- timeout_err  output  1  sticky; set on abort, cleared by next accepted start.

Behaviour:
- Reset (synchronous, active-high):
  - all outputs are 0; state is IDLE; counters and synchroniser flops are cleared.
  - reset wins over start in the same cycle.
  - reset mid-measurement aborts with no valid and no timeout_err.
- Synchroniser and edge detect:
  - `sig_in` passes through SYNC_STAGES flops to give `s`; `s_d` is `s` delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: busy=0. start=1 moves to ARM, clears the timeout counter and clears timeout_err. Edges seen in IDLE are ignored.
  - ARM: busy=1. On rise, go to HIGH with hcnt=1. If `sig_in` is already high at start, wait for the next rise.
  - HIGH: each cycle without fall, hcnt++. On fall, go to LOW with lcnt=1.
  - LOW: each cycle without rise, lcnt++. On rise: period<=hcnt+lcnt, high_time<=hcnt, valid<=1 for one cycle, busy<=0, return to IDLE.
- start while busy is ignored.
- valid and the result update occur on the same edge; period/high_time hold until the next valid.
- Counters saturate at all-ones (no wrap); period saturates the same way.
- Timeout: tcnt counts every cycle in ARM/HIGH/LOW.
  - On the cycle tcnt reaches TIMEOUT-1 without completing: go to IDLE, busy=0, timeout_err=1, no valid, results unchanged.
  - If completion and timeout coincide, completion wins.
- Latency: valid rises SYNC_STAGES+1 edges after the edge that first samples the closing `sig_in` high.
- Resolution is ±1 cycle for async `sig_in`; exact for a synchronous divider output.

Test Plan:
- Divider with DIVISOR=2 drives `sig_in`; pulse start → valid once, period=2, high_time=1, timeout_err=0.
- Divider with DIVISOR=10 → period=10, high_time=5. Second start → identical results.
- Synchronous `sig_in` high 3 / low 7 cycles, start issued while `sig_in` is high → first partial high ignored; period=10, high_time=3.
- `sig_in` held 0, TIMEOUT=1000, start → busy for 1000 cycles, then busy=0, timeout_err=1, no valid. Next start clears timeout_err.
- reset asserted during HIGH → next cycle all outputs 0, state IDLE. Fresh start with DIVISOR=4 → period=4, high_time=2.
- start pulsed again mid-measurement with DIVISOR=6 → ignored; exactly one valid, period=6.

Source files
------------

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period and high time of a slow square wave in clock_in cycles
//
// Purpose:
//   Sits at the measuring end of a clock-divider path. One start request
//   arms a single measurement: wait for a rising edge of sig_in, count the
//   high phase up to the falling edge, count the low phase up to the next
//   rising edge, then publish period = high + low and high_time = high.
//   A watchdog aborts the measurement if it does not finish within TIMEOUT
//   clock_in cycles of the start.
//
// Ports:
//   clock_in     in   system clock, everything on the rising edge
//   reset        in   synchronous, active-high reset
//   sig_in       in   slow signal under measurement, asynchronous
//   start        in   one-cycle request for one measurement (ignored while busy)
//   busy         out  measurement in progress
//   valid        out  one-cycle pulse, period/high_time updated on this cycle
//   period       out  rising-to-rising interval in clock_in cycles (saturating)
//   high_time    out  rising-to-falling interval in clock_in cycles (saturating)
//   timeout_err  out  sticky abort flag, cleared by the next accepted start

module clock_period_meter #(
    parameter int                   CNT_WIDTH   = 28,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT     = 28'd100_000_000,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = TIMEOUT - ONE;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise_q;
    logic                   fall_q;

    logic [CNT_WIDTH-1:0]   hcnt;
    logic [CNT_WIDTH-1:0]   lcnt;
    logic [CNT_WIDTH-1:0]   tcnt;

    logic [CNT_WIDTH:0]     sum_full;
    logic [CNT_WIDTH-1:0]   sum_sat;

    logic                   start_ok;
    logic                   done;
    logic                   tmo_hit;
    logic                   abort;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and edge detect
    // ------------------------------------------------------------------
    // The edge pulses are registered so that the FSM acts on a clean flop
    // output; both edges get the same extra cycle, so the measured
    // intervals are unaffected.
    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
            rise_q <= s & ~s_d;
            fall_q <= ~s & s_d;
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    assign start_ok = (state == IDLE) && start;
    assign done     = (state == LOW) && rise_q;
    assign tmo_hit  = (tcnt == TMO_LAST);
    // Completion on the timeout cycle takes priority over the abort.
    assign abort    = (state != IDLE) && tmo_hit && !done;

    assign sum_full = {1'b0, hcnt} + {1'b0, lcnt};
    assign sum_sat  = sum_full[CNT_WIDTH] ? '1 : sum_full[CNT_WIDTH-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_ok) state_nx = ARM;
            // A high level already present at start produces no rise, so ARM
            // naturally waits for the next full high phase.
            ARM:  if (rise_q)   state_nx = HIGH;
            HIGH: if (fall_q)   state_nx = LOW;
            LOW:  if (rise_q)   state_nx = IDLE;
            default:            state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Counters, watchdog and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            hcnt        <= '0;
            lcnt        <= '0;
            tcnt        <= '0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            valid <= 1'b0;

            if (state == IDLE) begin
                if (start) begin
                    tcnt        <= '0;
                    timeout_err <= 1'b0;
                end
            end else begin
                tcnt <= sat_inc(tcnt);
                if (abort) begin
                    timeout_err <= 1'b1;
                end
            end

            case (state)
                ARM: begin
                    if (rise_q) begin
                        hcnt <= ONE;
                    end
                end
                HIGH: begin
                    if (fall_q) begin
                        lcnt <= ONE;
                    end else begin
                        hcnt <= sat_inc(hcnt);
                    end
                end
                LOW: begin
                    if (rise_q) begin
                        period    <= sum_sat;
                        high_time <= hcnt;
                        valid     <= 1'b1;
                    end else begin
                        lcnt <= sat_inc(lcnt);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - self-checking bench for clock_period_meter

module tb_clock_period_meter;

    localparam int CW = 28;

    logic          clock_in = 1'b0;
    logic          reset    = 1'b1;
    logic          sig_in   = 1'b0;
    logic          start    = 1'b0;
    logic          busy;
    logic          valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          timeout_err;

    always #5 clock_in = ~clock_in;

    clock_period_meter #(
        .CNT_WIDTH   (CW),
        .TIMEOUT     (28'd1000),
        .SYNC_STAGES (2)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .start       (start),
        .busy        (busy),
        .valid       (valid),
        .period      (period),
        .high_time   (high_time),
        .timeout_err (timeout_err)
    );

    typedef struct {
        logic [CW-1:0] period;
        logic [CW-1:0] high;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   failures    = 0;
    int   valid_count = 0;

    // Synchronous divider model: high for sg_high cycles out of sg_period.
    bit sg_en     = 1'b0;
    int sg_period = 2;
    int sg_high   = 1;
    int sg_cnt    = 0;

    always @(negedge clock_in) begin
        if (sg_en) begin
            sig_in = (sg_cnt < sg_high);
            sg_cnt = (sg_cnt + 1 >= sg_period) ? 0 : sg_cnt + 1;
        end else begin
            sig_in = 1'b0;
            sg_cnt = 0;
        end
    end

    always @(negedge clock_in) begin
        if (valid === 1'b1) valid_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic set_div(input int p, input int h);
        sg_period = p;
        sg_high   = h;
        sg_en     = 1'b1;
    endtask

    task automatic push_exp(input int p, input int h);
        exp_t e;
        e.period = p[CW-1:0];
        e.high   = h[CW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic pulse_start;
        @(negedge clock_in);
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clock_in);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock_in);
        @(negedge clock_in);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock_in);
            if (valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clock_in);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clock_in);
        @(negedge clock_in);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (period !== '0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
        checks++; if (high_time !== '0) begin failures++; $display("FAIL reset_high got=%0d exp=0", high_time); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_tmo got=%b exp=0", timeout_err); end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock_in);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_wins_start got=%b exp=0", busy); end
    endtask

    task automatic test_div2;
        bit   got;
        exp_t e;
        set_div(2, 1);
        repeat (4) @(negedge clock_in);
        pulse_start();
        push_exp(2, 1);
        wait_valid(100, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++; $display("FAIL div2_valid got=none exp=pulse");
        end else begin
            if (period !== e.period) begin failures++; $display("FAIL div2_period got=%0d exp=%0d", period, e.period); end
            checks++; if (high_time !== e.high) begin failures++; $display("FAIL div2_high got=%0d exp=%0d", high_time, e.high); end
            checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL div2_tmo got=%b exp=0", timeout_err); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div2_busy got=%b exp=0", busy); end
            @(negedge clock_in);
            checks++; if (valid !== 1'b0) begin failures++; $display("FAIL div2_pulse got=%b exp=0", valid); end
            checks++; if (period !== e.period) begin failures++; $display("FAIL div2_hold got=%0d exp=%0d", period, e.period); end
        end
    endtask

    task automatic test_div10;
        bit   got;
        exp_t e;
        set_div(10, 5);
        for (int k = 0; k < 2; k++) begin
            repeat (3) @(negedge clock_in);
            pulse_start();
            push_exp(10, 5);
            wait_valid(100, got);
            e = exp_q.pop_front();
            checks++;
            if (!got) begin
                failures++; $display("FAIL div10_valid run=%0d got=none exp=pulse", k);
            end else begin
                if (period !== e.period) begin failures++; $display("FAIL div10_period run=%0d got=%0d exp=%0d", k, period, e.period); end
                checks++; if (high_time !== e.high) begin failures++; $display("FAIL div10_high run=%0d got=%0d exp=%0d", k, high_time, e.high); end
            end
        end
    endtask

    task automatic test_partial_high;
        bit   got;
        bit   seen;
        exp_t e;
        set_div(10, 3);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock_in);
            #1;
            if (sig_in === 1'b1) seen = 1'b1;
        end
        start = 1'b1;
        @(negedge clock_in);
        start = 1'b0;
        push_exp(10, 3);
        wait_valid(100, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || !seen) begin
            failures++; $display("FAIL partial_valid got=%b/%b exp=1/1", got, seen);
        end else begin
            if (period !== e.period) begin failures++; $display("FAIL partial_period got=%0d exp=%0d", period, e.period); end
            checks++; if (high_time !== e.high) begin failures++; $display("FAIL partial_high got=%0d exp=%0d", high_time, e.high); end
        end
    endtask

    task automatic test_timeout;
        int vc0;
        int busy_cycles;
        sg_en = 1'b0;
        repeat (5) @(negedge clock_in);
        vc0 = valid_count;
        pulse_start();
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 2000) begin
            busy_cycles++;
            @(negedge clock_in);
        end
        checks++; if (busy_cycles != 1000) begin failures++; $display("FAIL tmo_busy_cycles got=%0d exp=1000", busy_cycles); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", timeout_err); end
        checks++; if (valid_count != vc0) begin failures++; $display("FAIL tmo_no_valid got=%0d exp=%0d", valid_count, vc0); end
        checks++; if (period !== 28'd10) begin failures++; $display("FAIL tmo_period_kept got=%0d exp=10", period); end
        checks++; if (high_time !== 28'd3) begin failures++; $display("FAIL tmo_high_kept got=%0d exp=3", high_time); end
        pulse_start();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", timeout_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL tmo_restart_busy got=%b exp=1", busy); end
    endtask

    task automatic test_reset_mid;
        bit   got;
        bit   in_high;
        int   vc0;
        exp_t e;
        do_reset();
        set_div(20, 10);
        pulse_start();
        in_high = 1'b0;
        for (int i = 0; i < 100 && !in_high; i++) begin
            @(negedge clock_in);
            if (dut.state === 2'd2) in_high = 1'b1;
        end
        checks++; if (!in_high) begin failures++; $display("FAIL rmid_reach_high got=0 exp=1"); end
        vc0 = valid_count;
        reset = 1'b1;
        @(negedge clock_in);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (dut.state !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", dut.state); end
        checks++; if (period !== '0 || high_time !== '0) begin failures++; $display("FAIL rmid_results got=%0d/%0d exp=0/0", period, high_time); end
        checks++; if (valid !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rmid_flags got=%b/%b exp=0/0", valid, timeout_err); end
        repeat (30) @(negedge clock_in);
        checks++; if (valid_count != vc0) begin failures++; $display("FAIL rmid_no_valid got=%0d exp=%0d", valid_count, vc0); end
        set_div(4, 2);
        repeat (3) @(negedge clock_in);
        pulse_start();
        push_exp(4, 2);
        wait_valid(100, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++; $display("FAIL rmid_div4_valid got=none exp=pulse");
        end else begin
            if (period !== e.period) begin failures++; $display("FAIL rmid_div4_period got=%0d exp=%0d", period, e.period); end
            checks++; if (high_time !== e.high) begin failures++; $display("FAIL rmid_div4_high got=%0d exp=%0d", high_time, e.high); end
        end
    endtask

    task automatic test_back_to_back;
        bit   got;
        int   vc0;
        exp_t e;
        set_div(6, 3);
        repeat (3) @(negedge clock_in);
        vc0 = valid_count;
        pulse_start();
        push_exp(6, 3);
        @(negedge clock_in);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        pulse_start();
        wait_valid(100, got);
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++; $display("FAIL b2b_valid got=none exp=pulse");
        end else begin
            if (period !== e.period) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", period, e.period); end
            checks++; if (high_time !== e.high) begin failures++; $display("FAIL b2b_high got=%0d exp=%0d", high_time, e.high); end
        end
        repeat (40) @(negedge clock_in);
        checks++; if (valid_count != vc0 + 1) begin failures++; $display("FAIL b2b_one_valid got=%0d exp=%0d", valid_count - vc0, 1); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    initial begin
        repeat (3) @(negedge clock_in);
        reset = 1'b0;
        test_reset();
        test_div2();
        test_div10();
        test_partial_high();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
